// File: rtl/pipelined_adder_flags_if.sv
// ============================================================================
// Module      : pipelined_adder_flags_if
// Description : Issue/result handshake bundle for the pipelined adder with
//               operands, ADD/SUB/ADC/SBC controls, result and NZCV flags.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface pipelined_adder_flags_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             sub;
    logic             use_carry;
    logic             carry_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             flag_n;
    logic             flag_z;
    logic             flag_c;
    logic             flag_v;

    // Producer/consumer side of the adder.
    modport master (
        output in_valid, A, B, sub, use_carry, carry_in, out_ready,
        input  in_ready, out_valid, result, flag_n, flag_z, flag_c, flag_v
    );

    // The adder itself.
    modport slave (
        input  in_valid, A, B, sub, use_carry, carry_in, out_ready,
        output in_ready, out_valid, result, flag_n, flag_z, flag_c, flag_v
    );
endinterface

`default_nettype wire

// File: rtl/pipelined_adder_flags.sv
// ============================================================================
// Module      : pipelined_adder_flags
// Description : STAGES-deep ripple-slice adder/subtractor producing NZCV
//               flags, with a globally stalled valid/ready pipeline.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module pipelined_adder_flags #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    pipelined_adder_flags_if.slave  bus
);

    localparam int C_SLICE = WIDTH / STAGES;

    // Stage-input views: index s is what stage s consumes this cycle.
    logic             w_valid [STAGES];
    logic [WIDTH-1:0] w_a     [STAGES];
    logic [WIDTH-1:0] w_b     [STAGES];
    logic [WIDTH-1:0] w_sum   [STAGES];
    logic             w_carry [STAGES];
    logic             w_zero  [STAGES];

    logic w_adv;
    logic w_out_valid;

    assign w_adv        = !w_out_valid || bus.out_ready;
    assign bus.in_ready = w_adv;

    assign w_valid[0] = bus.in_valid;
    assign w_a[0]     = bus.A;
    assign w_b[0]     = bus.sub ? ~bus.B : bus.B;
    assign w_sum[0]   = '0;
    assign w_carry[0] = bus.use_carry ? bus.carry_in : bus.sub;
    assign w_zero[0]  = 1'b1;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int C_LO = s * C_SLICE;
        localparam int C_HI = C_LO + C_SLICE - 1;

        logic [C_SLICE:0] w_add;
        logic [WIDTH-1:0] w_sum_nxt;
        logic             r_valid;
        logic             r_carry;
        logic             r_zero;
        logic [WIDTH-1:0] r_sum;

        assign w_add = {1'b0, w_a[s][C_HI:C_LO]}
                     + {1'b0, w_b[s][C_HI:C_LO]}
                     + {{C_SLICE{1'b0}}, w_carry[s]};

        always_comb begin
            w_sum_nxt              = w_sum[s];
            w_sum_nxt[C_HI:C_LO]   = w_add[C_SLICE-1:0];
        end

        // Data only moves with a valid op, so bubbles leave the last result in place.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_valid <= 1'b0;
                r_carry <= 1'b0;
                r_zero  <= 1'b0;
                r_sum   <= '0;
            end else if (w_adv) begin
                r_valid <= w_valid[s];
                if (w_valid[s]) begin
                    r_sum   <= w_sum_nxt;
                    r_carry <= w_add[C_SLICE];
                    r_zero  <= w_zero[s] && (w_add[C_SLICE-1:0] == '0);
                end
            end
        end

        if (s < STAGES - 1) begin : g_link
            logic [WIDTH-1:0] r_a;
            logic [WIDTH-1:0] r_b;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_adv && w_valid[s]) begin
                    r_a <= w_a[s];
                    r_b <= w_b[s];
                end
            end

            assign w_valid[s+1] = r_valid;
            assign w_a[s+1]     = r_a;
            assign w_b[s+1]     = r_b;
            assign w_sum[s+1]   = r_sum;
            assign w_carry[s+1] = r_carry;
            assign w_zero[s+1]  = r_zero;
        end else begin : g_last
            logic r_cmsb;

            // Carry into the MSB recovered from the MSB sum bit and its operands.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_cmsb <= 1'b0;
                end else if (w_adv && w_valid[s]) begin
                    r_cmsb <= w_add[C_SLICE-1] ^ w_a[s][WIDTH-1] ^ w_b[s][WIDTH-1];
                end
            end

            assign w_out_valid = r_valid;
            assign bus.out_valid = r_valid;
            assign bus.result    = r_sum;
            assign bus.flag_n    = r_sum[WIDTH-1];
            assign bus.flag_z    = r_zero;
            assign bus.flag_c    = r_carry;
            assign bus.flag_v    = r_cmsb ^ r_carry;
        end
    end

endmodule

`default_nettype wire
